// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: mode encoding, FSM state type and mode-decode helpers for shiftreg_univ
package shiftreg_pkg;
  localparam logic [2:0] M_LOAD = 3'd0;
  localparam logic [2:0] M_SHR  = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_ROR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ASR  = 3'd5;
  localparam logic [2:0] M_NOP  = 3'd6;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic logic is_step(input logic [2:0] m);
    return m >= M_SHR && m <= M_ASR;
  endfunction
  function automatic logic is_right(input logic [2:0] m);
    return m == M_SHR || m == M_ROR || m == M_ASR;
  endfunction
endpackage

// File: rtl/shiftreg_step.sv
// shiftreg_step: one single-bit shift/rotate step of the register word, per mode
module shiftreg_step
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_nxt
);
  always_comb
    q_nxt = mode == M_SHR ? {ser_in, q[WIDTH-1:1]} :
            mode == M_SHL ? {q[WIDTH-2:0], ser_in} :
            mode == M_ROR ? {q[0], q[WIDTH-1:1]} :
            mode == M_ROL ? {q[WIDTH-2:0], q[WIDTH-1]} :
            mode == M_ASR ? {q[WIDTH-1], q[WIDTH-1:1]} : q;
endmodule

// File: rtl/shiftreg_univ.sv
// shiftreg_univ: universal shift register executing one bit step per clock for a latched command
module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_word,
  output logic             q_out
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d, word_step;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             right_q, right_d;
  logic             accept;
  assign accept = state_q == IDLE && start;
  shiftreg_step #(.WIDTH(WIDTH)) u_step (
    .q      (word_q),
    .mode   (mode_q),
    .ser_in (ser_in),
    .q_nxt  (word_step)
  );
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    if (accept) begin
      mode_d  = mode;
      cnt_d   = amount;
      right_d = is_right(mode);
      state_d = is_step(mode) && amount != '0 ? RUN : FIN;
      word_d  = mode == M_LOAD ? d_in : word_q;
    end else if (state_q == RUN) begin
      word_d  = word_step;
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CNT_W'(1) ? FIN : RUN;
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      mode_q  <= M_NOP;
      cnt_q   <= '0;
      right_q <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
    end
  assign busy   = state_q != IDLE;
  assign done   = state_q == FIN;
  assign q_word = word_q;
  assign q_out  = right_q ? word_q[0] : word_q[WIDTH-1];
endmodule

// File: tb/tb_shiftreg_univ.sv
// tb_shiftreg_univ: randomized scoreboard bench against a whole-command arithmetic reference model
module tb_shiftreg_univ;
  localparam int W = 8;
  typedef struct {
    logic [7:0] word;
    logic       qout;
    int         lat;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n, start, ser_in;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [7:0] d_in;
  logic       busy, done, q_out;
  logic [7:0] q_word;
  exp_t       sbq[$];
  logic [7:0] m;
  logic       mdir;
  int         checks = 0;
  int         errors = 0;
  int         bcnt = 0;
  shiftreg_univ #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .d_in   (d_in),
    .ser_in (ser_in),
    .busy   (busy),
    .done   (done),
    .q_word (q_word),
    .q_out  (q_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask
  // k-bit logical shift with a constant fill bit; saturates to the fill pattern when k >= W
  function automatic logic [7:0] shr_fill(input logic [7:0] v, input int k, input logic s);
    logic [7:0] keep;
    if (k >= W) return {8{s}};
    keep = 8'hFF >> k;
    return (v >> k) | (s ? ~keep : 8'h00);
  endfunction
  function automatic logic [7:0] shl_fill(input logic [7:0] v, input int k, input logic s);
    logic [7:0] keep;
    if (k >= W) return {8{s}};
    keep = 8'hFF << k;
    return (v << k) | (s ? ~keep : 8'h00);
  endfunction
  function automatic logic [7:0] rot(input logic [7:0] v, input int k, input logic right);
    int r;
    logic [7:0] a, b;
    r = k % W;
    a = right ? v >> r : v << r;
    b = right ? v << (W - r) : v >> (W - r);
    return r == 0 ? v : a | b;
  endfunction
  task automatic issue(input logic [2:0] md, input int amt, input logic [7:0] din,
                       input logic s, output int lat);
    exp_t e;
    logic [7:0] r;
    r = md == 3'd0 ? din :
        md == 3'd1 ? shr_fill(m, amt, s) :
        md == 3'd2 ? shl_fill(m, amt, s) :
        md == 3'd3 ? rot(m, amt, 1'b1) :
        md == 3'd4 ? rot(m, amt, 1'b0) :
        md == 3'd5 ? shr_fill(m, amt, m[7]) : m;
    lat = (md >= 3'd1 && md <= 3'd5 && amt != 0) ? amt + 1 : 1;
    m = r;
    mdir = md == 3'd1 || md == 3'd3 || md == 3'd5;
    e.word = r;
    e.qout = mdir ? r[0] : r[7];
    e.lat = lat;
    sbq.push_back(e);
    start = 1'b1;
    mode = md;
    amount = 4'(amt);
    d_in = din;
    ser_in = s;
    @(negedge clk);
  endtask
  // Random start pulses and input churn while busy, plus a start on the done cycle: all must be ignored
  task automatic finish_cmd(input int lat);
    for (int i = 1; i < lat; i++) begin
      start = 1'($urandom);
      mode = 3'($urandom);
      amount = 4'($urandom);
      d_in = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b1;
    mode = 3'($urandom);
    amount = 4'($urandom);
    d_in = 8'($urandom);
    ser_in = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic cmd(input logic [2:0] md, input int amt, input logic [7:0] din, input logic s);
    int lat;
    issue(md, amt, din, s, lat);
    finish_cmd(lat);
  endtask
  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 want no command pending");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("q_word", 32'(q_word), 32'(e.word));
          chk("q_out", 32'(q_out), 32'(e.qout));
          chk("busy_cycles", bcnt, e.lat);
        end
      end
      if (!busy) bcnt = 0;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
  initial begin
    int lat;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 3'd0;
    amount = 4'd0;
    d_in = 8'h00;
    ser_in = 1'b0;
    m = 8'h00;
    mdir = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q_word", 32'(q_word), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(3'd0, 0, 8'hA5, 1'b0);
    cmd(3'd3, 3, 8'h00, 1'b0);
    cmd(3'd4, 11, 8'h00, 1'b0);
    cmd(3'd0, 0, 8'h81, 1'b0);
    cmd(3'd5, 2, 8'h00, 1'b1);
    cmd(3'd0, 0, 8'h81, 1'b0);
    cmd(3'd1, 2, 8'h00, 1'b0);
    cmd(3'd0, 0, 8'h00, 1'b0);
    cmd(3'd2, 8, 8'h00, 1'b1);
    cmd(3'd2, 0, 8'h3C, 1'b1);
    cmd(3'd6, 5, 8'h3C, 1'b1);
    cmd(3'd7, 0, 8'h3C, 1'b0);
    cmd(3'd1, 15, 8'h00, 1'b1);
    cmd(3'd0, 0, 8'hC3, 1'b0);
    issue(3'd3, 5, 8'h00, 1'b0, lat);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_q_word", 32'(q_word), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q_out", 32'(q_out), 0);
    void'(sbq.pop_back());
    m = 8'h00;
    mdir = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(3'd0, 0, 8'h5A, 1'b0);
    for (int i = 0; i < 150; i++)
      cmd(3'($urandom_range(0, 7)), $urandom_range(0, 15), 8'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    chk("drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
